// File: rtl/alu_pkg.sv
// Shared ALU definitions: opcodes, writeback destination codes and the
// result-stage state encoding.
package alu_pkg;

    localparam logic [4:0] OP_ADD = 5'b00000;
    localparam logic [4:0] OP_SUB = 5'b00001;
    localparam logic [4:0] OP_MUL = 5'b00010;
    localparam logic [4:0] OP_DIV = 5'b00011;
    localparam logic [4:0] OP_AND = 5'b00100;
    localparam logic [4:0] OP_OR  = 5'b00101;
    localparam logic [4:0] OP_SHL = 5'b00110;
    localparam logic [4:0] OP_SHR = 5'b00111;

    typedef enum logic [1:0] {
        WB_NONE = 2'b00,
        WB_GP   = 2'b01,
        WB_LO   = 2'b10,
        WB_HI   = 2'b11
    } wb_dest_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WB_LO,
        ST_WB_HI
    } wb_state_t;

endpackage

// File: rtl/alu_flags.sv
// Zero/negative condition flags of an ALU result; narrow ops look only at
// the low WIDTH bits.
module alu_flags #(
    parameter int unsigned WIDTH = 32
) (
    input  logic [2*WIDTH-1:0] result,
    input  logic               wide,
    output logic               zero,
    output logic               neg
);

    always_comb begin
        zero = 1'b0;
        neg  = 1'b0;
        if (wide) begin
            zero = (result == '0);
            neg  = result[2*WIDTH-1];
        end else begin
            zero = (result[WIDTH-1:0] == '0);
            neg  = result[WIDTH-1];
        end
    end

endmodule

// File: rtl/alu_result_stage.sv
// Captures the ALU result, computes flags and writes it back over the
// datapath bus in one (narrow) or two (mul/div: LO then HI) handshaked beats.
module alu_result_stage
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH   = 32,
    parameter logic [4:0]  MUL_SEL = OP_MUL,
    parameter logic [4:0]  DIV_SEL = OP_DIV
) (
    input  logic               Clock,
    input  logic               Clear,
    input  logic               Zin,
    input  logic [4:0]         Control,
    input  logic [2*WIDTH-1:0] reg_C,
    input  logic               wb_ready,
    output logic [WIDTH-1:0]   bus_out,
    output logic               bus_valid,
    output logic [1:0]         wb_dest,
    output logic               busy,
    output logic               flag_zero,
    output logic               flag_neg,
    output logic               overrun
);

    wb_state_t        state, state_next;
    logic [WIDTH-1:0] z_lo, z_hi;
    logic             wide;
    logic             in_wide;
    logic             new_zero, new_neg;
    logic             final_accept;
    logic             capture;

    assign in_wide = (Control == MUL_SEL) || (Control == DIV_SEL);

    alu_flags #(.WIDTH(WIDTH)) u_flags (
        .result (reg_C),
        .wide   (in_wide),
        .zero   (new_zero),
        .neg    (new_neg)
    );

    // A capture is allowed when idle or on the cycle the last beat is taken,
    // which lets back-to-back results stream without an IDLE bubble.
    assign final_accept = wb_ready &&
                          ((state == ST_WB_HI) || (state == ST_WB_LO && !wide));
    assign capture      = Zin && ((state == ST_IDLE) || final_accept);

    always_ff @(posedge Clock) begin
        if (Clear) begin
            state     <= ST_IDLE;
            z_lo      <= '0;
            z_hi      <= '0;
            wide      <= 1'b0;
            flag_zero <= 1'b0;
            flag_neg  <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            state <= state_next;
            if (capture) begin
                z_lo      <= reg_C[WIDTH-1:0];
                z_hi      <= reg_C[2*WIDTH-1:WIDTH];
                wide      <= in_wide;
                flag_zero <= new_zero;
                flag_neg  <= new_neg;
            end else if (Zin) begin
                overrun <= 1'b1;
            end
        end
    end

    always_comb begin
        state_next = state;
        if (capture) begin
            state_next = ST_WB_LO;
        end else begin
            unique case (state)
                ST_IDLE:  state_next = ST_IDLE;
                ST_WB_LO: if (wb_ready) state_next = wide ? ST_WB_HI : ST_IDLE;
                ST_WB_HI: if (wb_ready) state_next = ST_IDLE;
                default:  state_next = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        bus_out   = '0;
        bus_valid = 1'b0;
        wb_dest   = WB_NONE;
        busy      = 1'b0;
        unique case (state)
            ST_WB_LO: begin
                bus_out   = z_lo;
                bus_valid = 1'b1;
                wb_dest   = wide ? WB_LO : WB_GP;
                busy      = 1'b1;
            end
            ST_WB_HI: begin
                bus_out   = z_hi;
                bus_valid = 1'b1;
                wb_dest   = WB_HI;
                busy      = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_alu_result_stage.sv
// Self-checking bench for alu_result_stage: directed scenarios plus random
// traffic checked against a queue-of-beats reference model.
module tb_alu_result_stage;

    logic        Clock = 1'b0;
    logic        Clear = 1'b0;
    logic        Zin = 1'b0;
    logic [4:0]  Control = '0;
    logic [63:0] reg_C = '0;
    logic        wb_ready = 1'b0;
    logic [31:0] bus_out;
    logic        bus_valid;
    logic [1:0]  wb_dest;
    logic        busy, flag_zero, flag_neg, overrun;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: pending writeback beats {data, dest} plus flag state.
    logic [33:0] q[$];
    logic        m_zero, m_neg, m_ovr;

    always #5 Clock = ~Clock;

    alu_result_stage #(.WIDTH(32), .MUL_SEL(5'b00010), .DIV_SEL(5'b00011)) dut (
        .Clock     (Clock),
        .Clear     (Clear),
        .Zin       (Zin),
        .Control   (Control),
        .reg_C     (reg_C),
        .wb_ready  (wb_ready),
        .bus_out   (bus_out),
        .bus_valid (bus_valid),
        .wb_dest   (wb_dest),
        .busy      (busy),
        .flag_zero (flag_zero),
        .flag_neg  (flag_neg),
        .overrun   (overrun)
    );

    function automatic logic [38:0] act_vec();
        return {bus_valid, bus_out, wb_dest, busy, flag_zero, flag_neg, overrun};
    endfunction

    function automatic logic [38:0] exp_vec();
        logic v;
        v = (q.size() != 0);
        return {v, v ? q[0][33:2] : 32'h0, v ? q[0][1:0] : 2'b00, v, m_zero, m_neg, m_ovr};
    endfunction

    // Apply inputs for one cycle, advance the model at the edge, return at negedge.
    task automatic tick(input logic clr, input logic zin, input logic [4:0] ctl,
                        input logic [63:0] c, input logic rdy);
        logic was_empty, fin, w;
        Clear = clr; Zin = zin; Control = ctl; reg_C = c; wb_ready = rdy;
        @(posedge Clock);
        if (clr) begin
            q.delete(); m_zero = 0; m_neg = 0; m_ovr = 0;
        end else begin
            was_empty = (q.size() == 0);
            fin = 0;
            if (!was_empty && rdy) begin
                void'(q.pop_front());
                fin = (q.size() == 0);
            end
            if (zin) begin
                if (was_empty || fin) begin
                    w = (ctl == 5'd2) || (ctl == 5'd3);
                    if (w) begin
                        q.push_back({c[31:0], 2'b10});
                        q.push_back({c[63:32], 2'b11});
                        m_zero = (c == 64'h0);
                        m_neg  = c[63];
                    end else begin
                        q.push_back({c[31:0], 2'b01});
                        m_zero = (c[31:0] == 32'h0);
                        m_neg  = c[31];
                    end
                end else begin
                    m_ovr = 1;
                end
            end
        end
        @(negedge Clock);
    endtask

    task automatic test_reset();
        tick(1, 0, 0, 0, 0);
        tick(1, 1, 5'd2, 64'hDEAD_BEEF_0000_0001, 1);
        n_checks++;
        if (act_vec() !== 39'h0) begin
            n_fail++;
            $display("FAIL reset: got %h want %h", act_vec(), 39'h0);
        end
    endtask

    task automatic test_add();
        tick(0, 1, 5'd0, 64'h5, 1);
        n_checks++;
        if (act_vec() !== exp_vec() || bus_out !== 32'd5 || wb_dest !== 2'b01 || bus_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL add_beat: got %h want %h", act_vec(), exp_vec());
        end
        tick(0, 0, 5'd0, 64'h0, 1);
        n_checks++;
        if (act_vec() !== exp_vec() || bus_valid !== 1'b0 || flag_zero !== 1'b0 || flag_neg !== 1'b0) begin
            n_fail++;
            $display("FAIL add_done: got %h want %h", act_vec(), exp_vec());
        end
    endtask

    task automatic test_mul();
        tick(0, 1, 5'd2, 64'hFFFF_FFFF_8000_0000, 1);
        n_checks++;
        if (act_vec() !== exp_vec() || bus_out !== 32'h8000_0000 || wb_dest !== 2'b10 || flag_neg !== 1'b1) begin
            n_fail++;
            $display("FAIL mul_lo: got %h want %h", act_vec(), exp_vec());
        end
        tick(0, 0, 5'd0, 64'h0, 1);
        n_checks++;
        if (act_vec() !== exp_vec() || bus_out !== 32'hFFFF_FFFF || wb_dest !== 2'b11) begin
            n_fail++;
            $display("FAIL mul_hi: got %h want %h", act_vec(), exp_vec());
        end
        tick(0, 0, 5'd0, 64'h0, 1);
        n_checks++;
        if (act_vec() !== exp_vec() || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL mul_done: got %h want %h", act_vec(), exp_vec());
        end
    endtask

    task automatic test_stall();
        tick(0, 1, 5'd3, 64'h0000_0003_0000_0007, 0);
        for (int i = 0; i < 4; i++) begin
            tick(0, 0, 5'($urandom), {$urandom, $urandom}, 0);
            n_checks++;
            if (act_vec() !== exp_vec() || bus_out !== 32'd7 || wb_dest !== 2'b10) begin
                n_fail++;
                $display("FAIL stall_hold%0d: got %h want %h", i, act_vec(), exp_vec());
            end
        end
        tick(0, 0, 5'd0, 64'h0, 1);
        n_checks++;
        if (act_vec() !== exp_vec() || bus_out !== 32'd3 || wb_dest !== 2'b11) begin
            n_fail++;
            $display("FAIL stall_hi: got %h want %h", act_vec(), exp_vec());
        end
        tick(0, 0, 5'd0, 64'h0, 1);
    endtask

    task automatic test_back_to_back();
        tick(0, 1, 5'd0, 64'h11, 1);
        tick(0, 1, 5'd1, 64'h22, 1);
        n_checks++;
        if (act_vec() !== exp_vec() || bus_valid !== 1'b1 || bus_out !== 32'h22 || overrun !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_narrow: got %h want %h", act_vec(), exp_vec());
        end
        tick(0, 1, 5'd2, 64'hAAAA_0000_BBBB_0000, 1);
        tick(0, 0, 5'd0, 64'h0, 1);
        tick(0, 1, 5'd0, 64'h33, 1);
        n_checks++;
        if (act_vec() !== exp_vec() || bus_out !== 32'h33 || wb_dest !== 2'b01 || overrun !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_wide: got %h want %h", act_vec(), exp_vec());
        end
        tick(0, 0, 5'd0, 64'h0, 1);
    endtask

    task automatic test_overrun();
        tick(0, 1, 5'd2, 64'h0000_0009_0000_0008, 0);
        tick(0, 1, 5'd0, 64'h77, 0);
        n_checks++;
        if (act_vec() !== exp_vec() || overrun !== 1'b1 || bus_out !== 32'd8) begin
            n_fail++;
            $display("FAIL overrun_set: got %h want %h", act_vec(), exp_vec());
        end
        for (int i = 0; i < 3; i++) tick(0, 0, 5'd0, 64'h0, 1);
        n_checks++;
        if (act_vec() !== exp_vec() || overrun !== 1'b1) begin
            n_fail++;
            $display("FAIL overrun_sticky: got %h want %h", act_vec(), exp_vec());
        end
        tick(1, 0, 5'd0, 64'h0, 0);
        n_checks++;
        if (act_vec() !== exp_vec() || overrun !== 1'b0) begin
            n_fail++;
            $display("FAIL overrun_clear: got %h want %h", act_vec(), exp_vec());
        end
    endtask

    task automatic test_zero_flag();
        tick(0, 1, 5'd0, 64'h1234_5678_0000_0000, 1);
        n_checks++;
        if (act_vec() !== exp_vec() || flag_zero !== 1'b1) begin
            n_fail++;
            $display("FAIL zero_narrow: got %h want %h", act_vec(), exp_vec());
        end
        tick(0, 0, 5'd0, 64'h0, 1);
        tick(0, 1, 5'd2, 64'h1234_5678_0000_0000, 1);
        n_checks++;
        if (act_vec() !== exp_vec() || flag_zero !== 1'b0) begin
            n_fail++;
            $display("FAIL zero_wide: got %h want %h", act_vec(), exp_vec());
        end
        tick(0, 0, 5'd0, 64'h0, 1);
        tick(0, 0, 5'd0, 64'h0, 1);
    endtask

    task automatic test_clear_mid();
        tick(0, 1, 5'd3, 64'h8000_0001_0000_0002, 1);
        tick(0, 1, 5'd0, 64'h44, 1);
        tick(0, 0, 5'd0, 64'h0, 0);
        tick(1, 1, 5'd0, 64'h55, 0);
        n_checks++;
        if (act_vec() !== exp_vec() || act_vec() !== 39'h0) begin
            n_fail++;
            $display("FAIL clear_mid: got %h want %h", act_vec(), exp_vec());
        end
        tick(0, 1, 5'd1, 64'h8000_0000, 1);
        n_checks++;
        if (act_vec() !== exp_vec() || bus_out !== 32'h8000_0000 || flag_neg !== 1'b1) begin
            n_fail++;
            $display("FAIL clear_resume: got %h want %h", act_vec(), exp_vec());
        end
        tick(0, 0, 5'd0, 64'h0, 1);
    endtask

    task automatic test_random(input int unsigned n);
        logic [4:0]  ctl;
        logic [63:0] c;
        for (int unsigned i = 0; i < n; i++) begin
            ctl = ($urandom_range(0, 2) == 0) ? 5'($urandom) : 5'($urandom_range(0, 3));
            c = {$urandom, $urandom};
            if ($urandom_range(0, 5) == 0) c[31:0] = '0;
            if ($urandom_range(0, 5) == 0) c[63:32] = '0;
            tick($urandom_range(0, 40) == 0, $urandom_range(0, 2) != 0, ctl, c,
                 $urandom_range(0, 3) != 0);
            n_checks++;
            if (act_vec() !== exp_vec()) begin
                n_fail++;
                $display("FAIL random_%0d: got %h want %h", i, act_vec(), exp_vec());
            end
        end
    endtask

    initial begin
        m_zero = 0; m_neg = 0; m_ovr = 0;
        @(negedge Clock);
        test_reset();
        test_add();
        test_mul();
        test_stall();
        test_back_to_back();
        test_overrun();
        test_zero_flag();
        test_clear_mid();
        test_random(400);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
